// File: rtl/cl_sde_img_sched.sv
// Image scheduler: streams whole images from the input FIFO into the CNN when
// there is room in flight and output credit, then writes each result as RES_BEATS slices.
module cl_sde_img_sched #(
  parameter int IMG_BEATS    = 1024,
  parameter int RES_BEATS    = 7,
  parameter int MAX_INFLIGHT = 4,
  parameter int OUT_DEPTH    = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_enable,
  input  logic [15:0] inp_count,
  output logic        pix_rd_en,
  input  logic        cnn_vld,
  output logic        res_wr_en,
  output logic [2:0]  res_idx,
  input  logic        out_pop,
  output logic        sts_busy,
  output logic [2:0]  sts_inflight,
  output logic [31:0] sts_img_in,
  output logic [31:0] sts_img_out,
  output logic        sts_err_unexp,
  output logic        sts_err_ovr
);
  localparam int BW = (IMG_BEATS > 1) ? $clog2(IMG_BEATS) : 1;
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(IMG_BEATS - 1);
  localparam logic [CW-1:0] RB        = CW'(RES_BEATS);
  localparam logic [CW-1:0] DEPTH     = CW'(OUT_DEPTH);
  localparam logic [2:0]    LAST_IDX  = 3'(RES_BEATS - 1);

  typedef enum logic [1:0] {IDLE, WAIT, STREAM} state_t;

  state_t        state, state_nxt;
  logic [BW-1:0] beat;
  logic [2:0]    inflight, inflight_nxt;
  logic [CW-1:0] credit, cred_nxt;
  logic [CW:0]   cred_sum;
  logic          start, last_beat, cnn_acc;

  always_comb begin
    start     = (state == WAIT) && cfg_enable && (inp_count >= 16'(IMG_BEATS)) &&
                ({1'b0, inflight} < 4'(MAX_INFLIGHT)) && (credit >= RB);
    last_beat = (state == STREAM) && (beat == LAST_BEAT);
    cnn_acc   = cnn_vld && (inflight != 3'd0);
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_enable) state_nxt = WAIT;
      WAIT:    if (!cfg_enable) state_nxt = IDLE;
               else if (start) state_nxt = STREAM;
      STREAM:  if (last_beat) state_nxt = cfg_enable ? WAIT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Start only fires with credit >= RB, so the subtraction cannot underflow.
  always_comb begin
    cred_sum = {1'b0, credit} + {{CW{1'b0}}, out_pop};
    if (start) cred_sum = cred_sum - {1'b0, RB};
    cred_nxt = (cred_sum > {1'b0, DEPTH}) ? DEPTH : cred_sum[CW-1:0];
  end

  always_comb begin
    inflight_nxt = inflight;
    case ({last_beat, cnn_acc})
      2'b10:   inflight_nxt = inflight + 3'd1;
      2'b01:   inflight_nxt = inflight - 3'd1;
      default: inflight_nxt = inflight;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pix_rd_en  <= 1'b0;
      beat       <= '0;
      inflight   <= '0;
      credit     <= DEPTH;
      sts_img_in <= '0;
    end else begin
      state      <= state_nxt;
      pix_rd_en  <= (state_nxt == STREAM);
      beat       <= (state == STREAM && !last_beat) ? beat + BW'(1) : '0;
      inflight   <= inflight_nxt;
      credit     <= cred_nxt;
      if (last_beat) sts_img_in <= sts_img_in + 32'd1;
    end
  end

  // A result arriving mid-write is dropped; the running sequence is never restarted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_wr_en     <= 1'b0;
      res_idx       <= '0;
      sts_img_out   <= '0;
      sts_err_unexp <= 1'b0;
      sts_err_ovr   <= 1'b0;
    end else begin
      if (res_wr_en) begin
        if (res_idx == LAST_IDX) begin
          res_wr_en   <= 1'b0;
          res_idx     <= '0;
          sts_img_out <= sts_img_out + 32'd1;
        end else begin
          res_idx <= res_idx + 3'd1;
        end
      end else if (cnn_acc) begin
        res_wr_en <= 1'b1;
        res_idx   <= '0;
      end
      if (cnn_vld && inflight == 3'd0) sts_err_unexp <= 1'b1;
      if (cnn_acc && res_wr_en)        sts_err_ovr   <= 1'b1;
    end
  end

  assign sts_inflight = inflight;
  assign sts_busy     = (state != IDLE) || (inflight != 3'd0);
endmodule

// File: tb/tb_cl_sde_img_sched.sv
// Bench for cl_sde_img_sched: phase table, directed corner sequences, and a
// random run checked every cycle against a count-based reference model.
module tb_cl_sde_img_sched;
  localparam int IMG = 1024, RB = 7, MAXI = 4, DEPTH = 14;

  logic        clk = 1'b0, rst_n = 1'b0, cfg_enable = 1'b0, cnn_vld = 1'b0, out_pop = 1'b0;
  logic [15:0] inp_count = '0;
  logic        pix_rd_en, res_wr_en, sts_busy, sts_err_unexp, sts_err_ovr;
  logic [2:0]  res_idx, sts_inflight;
  logic [31:0] sts_img_in, sts_img_out;

  int checks = 0, failures = 0;
  bit chk_on = 1'b0;

  cl_sde_img_sched #(.IMG_BEATS(IMG), .RES_BEATS(RB), .MAX_INFLIGHT(MAXI), .OUT_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .inp_count(inp_count),
    .pix_rd_en(pix_rd_en), .cnn_vld(cnn_vld), .res_wr_en(res_wr_en), .res_idx(res_idx),
    .out_pop(out_pop), .sts_busy(sts_busy), .sts_inflight(sts_inflight),
    .sts_img_in(sts_img_in), .sts_img_out(sts_img_out),
    .sts_err_unexp(sts_err_unexp), .sts_err_ovr(sts_err_ovr));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int n; bit rst; bit en; int cnt; bit vld; bit pop;
    bit pix; bit wr; int idx; int infl; int iin; int iout; bit eu; bit eo; bit busy;
  } vec_t;

  function automatic vec_t v(int n, bit rst, bit en, int cnt, bit vld, bit pop,
                             bit pix, bit wr, int idx, int infl, int iin, int iout,
                             bit eu, bit eo, bit busy);
    vec_t r;
    r.n = n; r.rst = rst; r.en = en; r.cnt = cnt; r.vld = vld; r.pop = pop;
    r.pix = pix; r.wr = wr; r.idx = idx; r.infl = infl; r.iin = iin; r.iout = iout;
    r.eu = eu; r.eo = eo; r.busy = busy;
    return r;
  endfunction

  task automatic run(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset;
    rst_n = 1'b0; cfg_enable = 1'b0; cnn_vld = 1'b0; out_pop = 1'b0; inp_count = '0;
    run(2);
    rst_n = 1'b1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference model: whole-image bookkeeping with plain counts.
  bit        m_wait, m_str, m_last, m_start, m_acc, s_wr;
  int        m_beats, m_infl, m_cred, m_wleft, m_widx, s_infl, s_cred;
  bit        m_eu, m_eo;
  bit [31:0] m_in, m_out;

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      m_wait = 0; m_str = 0; m_beats = 0; m_infl = 0; m_cred = DEPTH;
      m_in = 0; m_out = 0; m_wleft = 0; m_widx = 0; m_eu = 0; m_eo = 0;
    end else begin
      s_infl = m_infl; s_cred = m_cred; s_wr = (m_wleft > 0);
      m_last = 0; m_start = 0; m_acc = 0;
      if (m_str) begin
        m_beats++;
        if (m_beats == IMG) begin
          m_last = 1; m_beats = 0; m_str = 0; m_wait = cfg_enable; m_in++;
        end
      end else if (m_wait) begin
        if (!cfg_enable) m_wait = 0;
        else if (int'(inp_count) >= IMG && s_infl < MAXI && s_cred >= RB) begin
          m_start = 1; m_wait = 0; m_str = 1;
        end
      end else if (cfg_enable) m_wait = 1;
      m_cred = s_cred + int'(out_pop) - (m_start ? RB : 0);
      if (m_cred > DEPTH) m_cred = DEPTH;
      if (cnn_vld) begin
        if (s_infl == 0) m_eu = 1;
        else begin m_acc = 1; if (s_wr) m_eo = 1; end
      end
      m_infl = s_infl + int'(m_last) - int'(m_acc);
      if (m_wleft > 0) begin
        m_wleft--;
        if (m_wleft == 0) begin m_widx = 0; m_out++; end
        else m_widx++;
      end else if (m_acc) begin
        m_wleft = RB; m_widx = 0;
      end
    end
    #1;
    if (chk_on && rst_n) begin
      checks++;
      if (pix_rd_en !== m_str || res_wr_en !== (m_wleft > 0) || res_idx !== 3'(m_widx) ||
          sts_inflight !== 3'(m_infl) || sts_img_in !== m_in || sts_img_out !== m_out ||
          sts_err_unexp !== m_eu || sts_err_ovr !== m_eo ||
          sts_busy !== (m_wait || m_str || m_infl != 0)) begin
        failures++;
        $display("FAIL model t=%0t got pix=%b wr=%b idx=%0d infl=%0d in=%0d out=%0d eu=%b eo=%b busy=%b exp pix=%b wr=%b idx=%0d infl=%0d in=%0d out=%0d eu=%b eo=%b busy=%b",
                 $time, pix_rd_en, res_wr_en, res_idx, sts_inflight, sts_img_in, sts_img_out,
                 sts_err_unexp, sts_err_ovr, sts_busy, m_str, (m_wleft > 0), m_widx, m_infl,
                 m_in, m_out, m_eu, m_eo, (m_wait || m_str || m_infl != 0));
      end
    end
  end

  vec_t tbl[$];

  initial begin
    // single image; then credit stall, in-flight limit, overrun, last-beat/vld overlap
    tbl.push_back(v(1,    1, 0, 0,    0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(2,    0, 1, 1024, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(1023, 0, 1, 0,    0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(1,    0, 1, 0,    0, 0,  0, 0, 0, 1, 1, 0, 0, 0, 1));
    tbl.push_back(v(1,    0, 1, 0,    1, 0,  0, 1, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(v(6,    0, 1, 0,    0, 0,  0, 1, 6, 0, 1, 0, 0, 0, 1));
    tbl.push_back(v(1,    0, 1, 0,    0, 0,  0, 0, 0, 0, 1, 1, 0, 0, 1));
    tbl.push_back(v(2060, 1, 1, 8192, 0, 0,  0, 0, 0, 2, 2, 0, 0, 0, 1));
    tbl.push_back(v(7,    0, 1, 8192, 0, 1,  0, 0, 0, 2, 2, 0, 0, 0, 1));
    tbl.push_back(v(1,    0, 1, 8192, 0, 1,  1, 0, 0, 2, 2, 0, 0, 0, 1));
    tbl.push_back(v(4000, 0, 1, 8192, 0, 1,  0, 0, 0, 4, 4, 0, 0, 0, 1));
    tbl.push_back(v(1,    0, 1, 8192, 1, 1,  0, 1, 0, 3, 4, 0, 0, 0, 1));
    tbl.push_back(v(1,    0, 1, 8192, 0, 1,  1, 1, 1, 3, 4, 0, 0, 0, 1));
    tbl.push_back(v(2,    0, 1, 8192, 0, 1,  1, 1, 3, 3, 4, 0, 0, 0, 1));
    tbl.push_back(v(1,    0, 1, 8192, 1, 1,  1, 1, 4, 2, 4, 0, 0, 1, 1));
    tbl.push_back(v(3,    0, 1, 8192, 0, 1,  1, 0, 0, 2, 4, 1, 0, 1, 1));
    tbl.push_back(v(1017, 0, 1, 8192, 0, 1,  1, 0, 0, 2, 4, 1, 0, 1, 1));
    tbl.push_back(v(1,    0, 0, 8192, 1, 1,  0, 1, 0, 2, 5, 1, 0, 1, 1));

    #3;
    chk_on = 1'b1;
    chk("reset_pix", {31'd0, pix_rd_en}, 32'd0);
    chk("reset_credit_busy", {31'd0, sts_busy}, 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset;
      cfg_enable = tbl[i].en; inp_count = 16'(tbl[i].cnt); out_pop = tbl[i].pop;
      cnn_vld = tbl[i].vld;
      run(1);
      cnn_vld = 1'b0;
      run(tbl[i].n - 1);
      checks++;
      if (pix_rd_en !== tbl[i].pix || res_wr_en !== tbl[i].wr || res_idx !== 3'(tbl[i].idx) ||
          sts_inflight !== 3'(tbl[i].infl) || sts_img_in !== 32'(tbl[i].iin) ||
          sts_img_out !== 32'(tbl[i].iout) || sts_err_unexp !== tbl[i].eu ||
          sts_err_ovr !== tbl[i].eo || sts_busy !== tbl[i].busy) begin
        failures++;
        $display("FAIL vec[%0d] got pix=%b wr=%b idx=%0d infl=%0d in=%0d out=%0d eu=%b eo=%b busy=%b exp pix=%b wr=%b idx=%0d infl=%0d in=%0d out=%0d eu=%b eo=%b busy=%b",
                 i, pix_rd_en, res_wr_en, res_idx, sts_inflight, sts_img_in, sts_img_out,
                 sts_err_unexp, sts_err_ovr, sts_busy, tbl[i].pix, tbl[i].wr, tbl[i].idx,
                 tbl[i].infl, tbl[i].iin, tbl[i].iout, tbl[i].eu, tbl[i].eo, tbl[i].busy);
      end
    end

    // disable at beat 500: image completes, then the block idles
    do_reset;
    cfg_enable = 1'b1; inp_count = 16'd1024;
    run(502);
    cfg_enable = 1'b0;
    run(523);
    chk("dis_last_beat_pix", {31'd0, pix_rd_en}, 32'd1);
    run(1);
    chk("dis_done_pix", {31'd0, pix_rd_en}, 32'd0);
    chk("dis_done_img_in", sts_img_in, 32'd1);
    run(3);
    chk("dis_no_restart", {31'd0, pix_rd_en}, 32'd0);
    cnn_vld = 1'b1; run(1); cnn_vld = 1'b0;
    run(7);
    chk("dis_idle_busy", {31'd0, sts_busy}, 32'd0);
    chk("dis_img_out", sts_img_out, 32'd1);

    // reset at beat 300 kills the stream immediately and restores full credit
    do_reset;
    cfg_enable = 1'b1; inp_count = 16'd1024;
    run(302);
    chk("rst_pre_pix", {31'd0, pix_rd_en}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pix", {31'd0, pix_rd_en}, 32'd0);
    chk("rst_img_in", sts_img_in, 32'd0);
    chk("rst_inflight", {29'd0, sts_inflight}, 32'd0);
    chk("rst_busy", {31'd0, sts_busy}, 32'd0);
    run(2);
    rst_n = 1'b1;
    run(1027);
    chk("rst_credit_2nd_img", {31'd0, pix_rd_en}, 32'd1);
    chk("rst_credit_img_in", sts_img_in, 32'd1);

    // result with nothing in flight
    do_reset;
    cnn_vld = 1'b1; run(1); cnn_vld = 1'b0;
    chk("unexp_flag", {31'd0, sts_err_unexp}, 32'd1);
    chk("unexp_inflight", {29'd0, sts_inflight}, 32'd0);
    chk("unexp_no_write", {31'd0, res_wr_en}, 32'd0);
    chk("unexp_ovr", {31'd0, sts_err_ovr}, 32'd0);

    // random traffic against the model
    do_reset;
    for (int c = 0; c < 20000; c++) begin
      cfg_enable = ($urandom_range(0, 19) != 0);
      inp_count  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 1023))
                                               : 16'($urandom_range(1024, 4000));
      cnn_vld    = ($urandom_range(0, 499) == 0);
      out_pop    = ($urandom_range(0, 1) == 0);
      run(1);
    end
    cnn_vld = 1'b0; out_pop = 1'b0;
    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cl_sde_img_sched.md
CL_SDE_IMG_SCHED -- requirements
Module: cl_sde_img_sched

Interface
Parameters (name, default, meaning):
- REQ-001 The block SHALL have parameter IMG_BEATS, default 1024: input-FIFO beats per image.
- REQ-002 The block SHALL have parameter RES_BEATS, default 7: 160-bit result beats written per classification.
- REQ-003 The block SHALL have parameter MAX_INFLIGHT, default 4: maximum images streamed into the CNN and not yet classified.
- REQ-004 The block SHALL have parameter OUT_DEPTH, default 64: output-FIFO entries, which is also the initial credit count.

Ports (name, direction, width, meaning):
- REQ-005 The block SHALL have the following ports:
  - clk, in, 1: the single clock.
  - rst_n, in, 1: reset. Reset is asynchronous and active-low.
  - cfg_enable, in, 1: allows new images to start.
  - inp_count, in, 16: current input-FIFO occupancy in beats.
  - pix_rd_en, out, 1: input-FIFO read strobe, and CNN input valid.
  - cnn_vld, in, 1: one-cycle pulse when a CNN result is ready.
  - res_wr_en, out, 1: output-FIFO write strobe.
  - res_idx, out, 3: selects the 160-bit slice of the result to write.
  - out_pop, in, 1: output-FIFO read; returns one credit.
  - sts_busy, out, 1: state is not IDLE, or in-flight count is nonzero.
  - sts_inflight, out, 3: images currently in flight.
  - sts_img_in, out, 32: images fully streamed in.
  - sts_img_out, out, 32: results fully written.
  - sts_err_unexp, out, 1: sticky; cnn_vld seen while in-flight count was 0.
  - sts_err_ovr, out, 1: sticky; cnn_vld seen while a result was still being written.

Function
- REQ-006 The FSM SHALL have three states: IDLE, WAIT, STREAM.
- REQ-007 IDLE SHALL go to WAIT when cfg_enable=1; WAIT SHALL go to IDLE when cfg_enable=0.
- REQ-008 WAIT SHALL go to STREAM when all of the following hold in the same cycle:
  - inp_count >= IMG_BEATS;
  - inflight < MAX_INFLIGHT;
  - credit >= RES_BEATS.
- REQ-009 On the WAIT->STREAM transition, credit SHALL decrease by RES_BEATS.
- REQ-010 pix_rd_en SHALL be registered; it SHALL be 1 on exactly IMG_BEATS consecutive cycles, starting the cycle after the WAIT->STREAM decision.
- REQ-011 STREAM SHALL use a beat counter from 0 to IMG_BEATS-1; on the last beat:
  - inflight SHALL increment;
  - sts_img_in SHALL increment;
  - the next state SHALL be WAIT if cfg_enable=1, else IDLE.
- REQ-012 Deasserting cfg_enable during STREAM SHALL NOT truncate the image; the stream SHALL finish all IMG_BEATS beats.
- REQ-013 Back-to-back images SHALL be allowed: the decision cycle after the last beat may restart streaming, so pix_rd_en has a minimum one-cycle gap between images.
- REQ-014 When cnn_vld=1 and inflight>0, the block SHALL:
  - decrement inflight;
  - starting the next cycle, assert res_wr_en for RES_BEATS consecutive cycles, with res_idx = 0,1,...,RES_BEATS-1;
  - increment sts_img_out on the final write beat.
- REQ-015 When cnn_vld=1 and inflight=0, the block SHALL set sts_err_unexp and SHALL change no other state.
- REQ-016 When cnn_vld=1 while res_wr_en is active, the block SHALL:
  - set sts_err_ovr;
  - decrement inflight;
  - not restart the current write sequence;
  - drop the new result.
- REQ-017 When the last stream beat and an accepted cnn_vld fall in the same cycle, inflight SHALL be unchanged.
- REQ-018 Credit SHALL be a counter of width clog2(OUT_DEPTH+1):
  - +1 per out_pop;
  - -RES_BEATS at stream start;
  - both applied in the same cycle when simultaneous;
  - saturating at OUT_DEPTH;
  - never below 0, which the start condition guarantees.
- REQ-019 sts_img_in and sts_img_out SHALL wrap modulo 2^32 with no flag.
- REQ-020 The sticky error bits SHALL clear only on reset.

Reset
- REQ-021 On rst_n=0, asynchronously, the block SHALL set:
  - state = IDLE;
  - pix_rd_en = 0, res_wr_en = 0, res_idx = 0;
  - beat counter = 0, inflight = 0;
  - credit = OUT_DEPTH;
  - all status counters and errors = 0.
- REQ-022 Reset asserted mid-STREAM SHALL drop pix_rd_en immediately, and the partial image SHALL NOT be counted.
- REQ-023 After rst_n deasserts, the first transition SHALL occur no earlier than the first clk edge after deassertion.

Verification
- REQ-024 Single image: enable=1, inp_count=1024 -> pix_rd_en high for 1024 cycles, starting the cycle after; sts_img_in=1, sts_inflight=1; then cnn_vld pulse -> res_wr_en for 7 cycles with res_idx 0..6; sts_img_out=1, sts_inflight=0.
- REQ-025 In-flight limit: inp_count held at 8192, no cnn_vld -> exactly 4 images streamed, then WAIT with pix_rd_en=0; one cnn_vld -> a 5th image starts.
- REQ-026 Credit stall: OUT_DEPTH=14, no out_pop -> 2 images start and the 3rd stalls; 7 out_pop pulses -> the 3rd starts on the following decision cycle.
- REQ-027 Error cases: cnn_vld with inflight=0 -> sts_err_unexp=1 and counters unchanged; cnn_vld at res_idx=3 -> sts_err_ovr=1, write sequence continues 4..6, inflight decremented.
- REQ-028 Simultaneity and disable: last stream beat coincident with cnn_vld -> inflight unchanged; cfg_enable dropped at beat 500 -> all 1024 beats complete, then IDLE.
- REQ-029 Reset mid-stream: rst_n low at beat 300 -> pix_rd_en=0 immediately, all counters 0, credit=OUT_DEPTH.
